// File: rtl/id_stage_reg_pkg.sv
// Shared constants for the ID/EXE pipeline register.
// Holds the EXE command encodings, status-bit ordering and the bubble control word.
package id_stage_reg_pkg;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  // Status vector ordering is {z, c, n, v}.
  localparam int STATUS_Z = 3;
  localparam int STATUS_C = 2;
  localparam int STATUS_N = 1;
  localparam int STATUS_V = 0;

  typedef struct packed {
    logic valid;
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
    logic b;
    logic s;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_stage_reg_pipe_reg.sv
// Generic W-bit pipeline register with synchronous reset and a hold input.
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (!freeze) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_stage_reg.sv
// ID/EXE pipeline register: captures decoded control, operands and flags,
// turning the instruction into a bubble on flush, hazard, failed condition or empty ID.
module id_stage_reg
  import id_stage_reg_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze,
  input  logic                 flush,
  input  logic                 cond_pass,
  input  logic                 hazard,
  input  logic                 id_valid,
  input  logic                 wb_en_in,
  input  logic                 mem_r_en_in,
  input  logic                 mem_w_en_in,
  input  logic                 b_in,
  input  logic                 s_in,
  input  logic [3:0]           exe_cmd_in,
  input  logic [DATA_W-1:0]    pc_in,
  input  logic [DATA_W-1:0]    val_rn_in,
  input  logic [DATA_W-1:0]    val_rm_in,
  input  logic                 imm_in,
  input  logic [11:0]          shift_operand_in,
  input  logic [23:0]          signed_imm_24_in,
  input  logic [REG_IDX_W-1:0] dest_in,
  input  logic [REG_IDX_W-1:0] src1_in,
  input  logic [REG_IDX_W-1:0] src2_in,
  input  logic [3:0]           status_in,
  output logic                 valid_out,
  output logic                 wb_en_out,
  output logic                 mem_r_en_out,
  output logic                 mem_w_en_out,
  output logic                 b_out,
  output logic                 s_out,
  output logic [3:0]           exe_cmd_out,
  output logic [DATA_W-1:0]    pc_out,
  output logic [DATA_W-1:0]    val_rn_out,
  output logic [DATA_W-1:0]    val_rm_out,
  output logic                 imm_out,
  output logic [11:0]          shift_operand_out,
  output logic [23:0]          signed_imm_24_out,
  output logic [REG_IDX_W-1:0] dest_out,
  output logic [REG_IDX_W-1:0] src1_out,
  output logic [REG_IDX_W-1:0] src2_out,
  output logic [3:0]           status_out
);

  localparam int DW = 4 + 3*DATA_W + 1 + 12 + 24 + 3*REG_IDX_W + 4;

  logic          kill;
  logic          hold;
  ctrl_t         ctrl_d;
  ctrl_t         ctrl_q;
  logic [DW-1:0] data_d;
  logic [DW-1:0] data_q;

  // A taken branch must squash even a frozen instruction, so flush overrides the hold.
  assign kill = flush | hazard | ~cond_pass | ~id_valid;
  assign hold = freeze & ~flush;

  always_comb begin
    ctrl_d = BUBBLE_CTRL;
    if (!kill) begin
      ctrl_d = '{valid: 1'b1, wb_en: wb_en_in, mem_r_en: mem_r_en_in,
                 mem_w_en: mem_w_en_in, b: b_in, s: s_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= BUBBLE_CTRL;
    end else if (!hold) begin
      ctrl_q <= ctrl_d;
    end
  end

  assign valid_out    = ctrl_q.valid;
  assign wb_en_out    = ctrl_q.wb_en;
  assign mem_r_en_out = ctrl_q.mem_r_en;
  assign mem_w_en_out = ctrl_q.mem_w_en;
  assign b_out        = ctrl_q.b;
  assign s_out        = ctrl_q.s;

  // Data fields load even for bubbles; only the enables above are squashed.
  assign data_d = {exe_cmd_in, pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
                   signed_imm_24_in, dest_in, src1_in, src2_in, status_in};

  pipe_reg #(.W(DW)) u_data (
    .clk    (clk),
    .rst    (rst),
    .freeze (hold),
    .d      (data_d),
    .q      (data_q)
  );

  assign {exe_cmd_out, pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
          signed_imm_24_out, dest_out, src1_out, src2_out, status_out} = data_q;

endmodule

// File: tb/tb_id_stage_reg.sv
// Directed plus random scoreboard bench for the ID/EXE pipeline register.
module tb_id_stage_reg;

  typedef struct packed {
    logic        rst, freeze, flush, cond_pass, hazard, id_valid;
    logic        wb, mr, mw, b, s;
    logic [3:0]  exe;
    logic [31:0] pc, rn, rm;
    logic        imm;
    logic [11:0] shift;
    logic [23:0] off;
    logic [3:0]  dest, s1, s2;
    logic [3:0]  status;
  } in_t;

  typedef struct packed {
    logic        valid, wb, mr, mw, b, s;
    logic [3:0]  exe;
    logic [31:0] pc, rn, rm;
    logic        imm;
    logic [11:0] shift;
    logic [23:0] off;
    logic [3:0]  dest, s1, s2;
    logic [3:0]  status;
  } out_t;

  logic clk = 1'b0;
  in_t  stim;
  out_t obs;
  out_t model;
  out_t scoreboard[$];
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  id_stage_reg #(.DATA_W(32), .REG_IDX_W(4)) dut (
    .clk               (clk),
    .rst               (stim.rst),
    .freeze            (stim.freeze),
    .flush             (stim.flush),
    .cond_pass         (stim.cond_pass),
    .hazard            (stim.hazard),
    .id_valid          (stim.id_valid),
    .wb_en_in          (stim.wb),
    .mem_r_en_in       (stim.mr),
    .mem_w_en_in       (stim.mw),
    .b_in              (stim.b),
    .s_in              (stim.s),
    .exe_cmd_in        (stim.exe),
    .pc_in             (stim.pc),
    .val_rn_in         (stim.rn),
    .val_rm_in         (stim.rm),
    .imm_in            (stim.imm),
    .shift_operand_in  (stim.shift),
    .signed_imm_24_in  (stim.off),
    .dest_in           (stim.dest),
    .src1_in           (stim.s1),
    .src2_in           (stim.s2),
    .status_in         (stim.status),
    .valid_out         (obs.valid),
    .wb_en_out         (obs.wb),
    .mem_r_en_out      (obs.mr),
    .mem_w_en_out      (obs.mw),
    .b_out             (obs.b),
    .s_out             (obs.s),
    .exe_cmd_out       (obs.exe),
    .pc_out            (obs.pc),
    .val_rn_out        (obs.rn),
    .val_rm_out        (obs.rm),
    .imm_out           (obs.imm),
    .shift_operand_out (obs.shift),
    .signed_imm_24_out (obs.off),
    .dest_out          (obs.dest),
    .src1_out          (obs.s1),
    .src2_out          (obs.s2),
    .status_out        (obs.status)
  );

  // Reference behaviour: reset, then flush, then freeze, then kill, then load.
  function automatic out_t nextModel(in_t i, out_t prev);
    out_t n;
    logic kill;
    kill = i.flush | i.hazard | ~i.cond_pass | ~i.id_valid;
    n = '{valid: 1'b1, wb: i.wb, mr: i.mr, mw: i.mw, b: i.b, s: i.s, exe: i.exe,
          pc: i.pc, rn: i.rn, rm: i.rm, imm: i.imm, shift: i.shift, off: i.off,
          dest: i.dest, s1: i.s1, s2: i.s2, status: i.status};
    if (i.rst) begin
      n = '0;
    end else if (!i.flush && i.freeze) begin
      n = prev;
    end else if (kill) begin
      {n.valid, n.wb, n.mr, n.mw, n.b, n.s} = 6'b0;
    end
    return n;
  endfunction

  function automatic in_t validInstr(logic [31:0] pc, logic [3:0] exe, logic [3:0] status);
    in_t i;
    i = '0;
    i.cond_pass = 1'b1;
    i.id_valid  = 1'b1;
    i.pc        = pc;
    i.exe       = exe;
    i.status    = status;
    return i;
  endfunction

  function automatic in_t randomInstr();
    in_t i;
    i = in_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    i.rst    = ($urandom_range(0, 15) == 0);
    i.freeze = ($urandom_range(0, 3) == 0);
    i.flush  = ($urandom_range(0, 5) == 0);
    i.hazard = ($urandom_range(0, 5) == 0);
    return i;
  endfunction

  task automatic checkOutput(string tag, logic [127:0] observed, logic [127:0] expected);
    compared++;
    assert (observed === expected)
      else begin
        mismatched++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // Drive one step, push the predicted result, then pop and compare after the edge.
  task automatic applyStimulus(string tag, in_t i);
    out_t exp;
    @(negedge clk);
    stim = i;
    model = nextModel(i, model);
    scoreboard.push_back(model);
    @(posedge clk);
    #1;
    exp = scoreboard.pop_front();
    checkOutput({tag, ".ctrl"}, 128'({obs.valid, obs.wb, obs.mr, obs.mw, obs.b, obs.s}),
                128'({exp.valid, exp.wb, exp.mr, exp.mw, exp.b, exp.s}));
    checkOutput({tag, ".pc"}, 128'(obs.pc), 128'(exp.pc));
    checkOutput({tag, ".exe_cmd"}, 128'(obs.exe), 128'(exp.exe));
    checkOutput({tag, ".status"}, 128'(obs.status), 128'(exp.status));
    checkOutput({tag, ".fields"},
                128'({obs.rn, obs.rm, obs.imm, obs.shift, obs.off, obs.dest, obs.s1, obs.s2}),
                128'({exp.rn, exp.rm, exp.imm, exp.shift, exp.off, exp.dest, exp.s1, exp.s2}));
  endtask

  initial begin
    in_t a;
    in_t bI;
    stim  = '0;
    model = '0;

    // Reset with every input at 1.
    a = '1;
    applyStimulus("reset_all_ones", a);

    a = validInstr(32'h0000_0010, 4'b0010, 4'b0000);
    a.wb = 1'b1;
    applyStimulus("normal_load", a);
    checkOutput("normal_load.pc_const", 128'(obs.pc), 128'(32'h10));
    checkOutput("normal_load.valid_const", 128'(obs.valid), 128'(1'b1));

    a.cond_pass = 1'b0;
    applyStimulus("cond_fail", a);
    checkOutput("cond_fail.valid_const", 128'(obs.valid), 128'(1'b0));

    a = validInstr(32'h0000_0100, 4'b0011, 4'b0100);
    a.wb = 1'b1; a.s = 1'b1; a.rn = 32'hAAAA_5555; a.dest = 4'd3;
    applyStimulus("status_capture", a);
    checkOutput("status_capture.c_flag", 128'(obs.status), 128'(4'b0100));

    bI = validInstr(32'h0000_0200, 4'b0100, 4'b1000);
    bI.mr = 1'b1; bI.rm = 32'h1234_5678; bI.freeze = 1'b1;
    for (int k = 0; k < 3; k++) applyStimulus("freeze_hold", bI);
    bI.freeze = 1'b0;
    applyStimulus("freeze_release", bI);

    a = validInstr(32'h0000_0300, 4'b0001, 4'b0001);
    a.mw = 1'b1; a.freeze = 1'b1; a.flush = 1'b1;
    applyStimulus("flush_beats_freeze", a);

    a = validInstr(32'h0000_0400, 4'b0110, 4'b0010);
    a.b = 1'b1; a.hazard = 1'b1;
    applyStimulus("hazard_bubble", a);

    a.hazard = 1'b0; a.id_valid = 1'b0;
    applyStimulus("id_invalid_bubble", a);

    a.id_valid = 1'b1;
    applyStimulus("load_before_reset", a);
    a.rst = 1'b1; a.freeze = 1'b1;
    applyStimulus("reset_over_freeze", a);
    a.rst = 1'b0;
    applyStimulus("freeze_after_reset", a);

    for (int k = 0; k < 40; k++) applyStimulus("random", randomInstr());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
